// File: rtl/exec_mem_unit.sv
// Execute/memory stage of the single-cycle RV32I core: control decode, ALU,
// branch comparator and a little-endian byte-addressable data memory.
module exec_mem_unit #(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic [3:0]  sel_bit,
    output logic [31:0] alu_out,
    output logic [31:0] wb_data,
    output logic        wenb,
    output logic [31:0] next_pc,
    output logic        branch_taken
);

    localparam int IDX_W = ADDR_W - 2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] arith_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic a_is_pc;
    logic b_is_imm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;

    always_comb begin
        sel_bit   = ALU_ADD;
        a_is_pc   = 1'b0;
        b_is_imm  = 1'b1;
        wenb      = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP_R: begin
                sel_bit  = arith_sel(funct3, funct7_b5);
                b_is_imm = 1'b0;
                wenb     = 1'b1;
            end
            OP_I: begin
                sel_bit = arith_sel(funct3, (funct3 == 3'b101) && funct7_b5);
                wenb    = 1'b1;
            end
            OP_LOAD: begin
                is_load = 1'b1;
                wenb    = 1'b1;
            end
            OP_STORE: begin
                is_store = 1'b1;
            end
            OP_BRANCH: begin
                a_is_pc   = 1'b1;
                is_branch = 1'b1;
            end
            OP_LUI: begin
                sel_bit = ALU_PASS_B;
                wenb    = 1'b1;
            end
            OP_AUIPC: begin
                a_is_pc = 1'b1;
                wenb    = 1'b1;
            end
            OP_JAL: begin
                a_is_pc = 1'b1;
                is_jal  = 1'b1;
                wenb    = 1'b1;
            end
            OP_JALR: begin
                is_jalr = 1'b1;
                wenb    = 1'b1;
            end
            default: begin
                sel_bit = ALU_ADD;
            end
        endcase
    end

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;

    assign op_a  = a_is_pc ? pc : rs1_data;
    assign op_b  = b_is_imm ? imm : rs2_data;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = 32'd0;
        case (sel_bit)
            ALU_ADD:    alu_out = op_a + op_b;
            ALU_SUB:    alu_out = op_a - op_b;
            ALU_SLL:    alu_out = op_a << shamt;
            ALU_SLT:    alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_out = {31'd0, op_a < op_b};
            ALU_XOR:    alu_out = op_a ^ op_b;
            ALU_SRL:    alu_out = op_a >> shamt;
            ALU_SRA:    alu_out = 32'($signed(op_a) >>> shamt);
            ALU_OR:     alu_out = op_a | op_b;
            ALU_AND:    alu_out = op_a & op_b;
            ALU_PASS_B: alu_out = op_b;
            default:    alu_out = 32'd0;
        endcase
    end

    // Branch comparator is independent of the ALU, which is busy forming pc+imm.
    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_data == rs2_data);
            3'b001:  br_cond = (rs1_data != rs2_data);
            3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_cond = (rs1_data <  rs2_data);
            3'b111:  br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    logic [31:0] pc_plus4;

    assign pc_plus4     = pc + 32'd4;
    assign branch_taken = (is_branch && br_cond) || is_jal || is_jalr;

    always_comb begin
        if (is_jalr)
            next_pc = {alu_out[31:1], 1'b0};
        else if (branch_taken)
            next_pc = alu_out;
        else
            next_pc = pc_plus4;
    end

    // Upper address bits wrap; halfword/word accesses force alignment.
    logic [ADDR_W-1:0] mem_addr;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       mem [MEM_WORDS];
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    assign mem_addr = alu_out[ADDR_W-1:0];
    assign word_idx = mem_addr[ADDR_W-1:2];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{mem_addr[1:0], 3'b000} +: 8];
    assign rd_half  = rd_word[{mem_addr[1], 4'b0000} +: 16];

    always_comb begin
        load_data = 32'd0;
        case (funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        if (is_jal || is_jalr)
            wb_data = pc_plus4;
        else if (is_load)
            wb_data = load_data;
        else
            wb_data = alu_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_WORDS; i++)
                mem[i] <= 32'd0;
        end else if (is_store) begin
            case (funct3)
                3'b000:  mem[word_idx][{mem_addr[1:0], 3'b000} +: 8] <= rs2_data[7:0];
                3'b001:  mem[word_idx][{mem_addr[1], 4'b0000} +: 16] <= rs2_data[15:0];
                3'b010:  mem[word_idx] <= rs2_data;
                default: ;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                           alu_out[31:ADDR_W]};

endmodule

// File: tb/tb_exec_mem_unit.sv
// Randomized bench for exec_mem_unit: a driver pushes reference-model results
// into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_exec_mem_unit;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] alu;
        logic [31:0] wb;
        logic        wenb;
        logic [31:0] npc;
        logic        bt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [31:0] imm = 32'd0;
    logic [3:0]  sel_bit;
    logic [31:0] alu_out;
    logic [31:0] wb_data;
    logic        wenb;
    logic [31:0] next_pc;
    logic        branch_taken;

    exp_t  exp_q[$];
    string name_q[$];
    logic [7:0] mem_model [1024];
    int n_checks = 0;
    int n_fail   = 0;

    exec_mem_unit #(.MEM_WORDS(256), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .sel_bit(sel_bit), .alu_out(alu_out), .wb_data(wb_data),
        .wenb(wenb), .next_pc(next_pc), .branch_taken(branch_taken)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return 32'($signed(a) >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // funct3 to ALU code for R/I arithmetic; alt means SUB or SRA
    function automatic logic [3:0] op_code(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd7;
        return tbl[f3];
    endfunction

    function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned ad, h, w;
        logic [7:0]  b;
        logic [15:0] hw;
        ad = addr % 1024;
        h  = ad - (ad % 2);
        w  = ad - (ad % 4);
        b  = mem_model[ad];
        hw = {mem_model[h+1], mem_model[h]};
        case (f3)
            3'd0: return {{24{b[7]}}, b};
            3'd1: return {{16{hw[15]}}, hw};
            3'd2: return {mem_model[w+3], mem_model[w+2], mem_model[w+1], mem_model[w]};
            3'd4: return {24'd0, b};
            3'd5: return {16'd0, hw};
            default: return 32'd0;
        endcase
    endfunction

    task automatic store_ref(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
        int unsigned ad, h, w;
        ad = addr % 1024;
        h  = ad - (ad % 2);
        w  = ad - (ad % 4);
        case (f3)
            3'd0: mem_model[ad] = d[7:0];
            3'd1: begin mem_model[h] = d[7:0]; mem_model[h+1] = d[15:8]; end
            3'd2: for (int k = 0; k < 4; k++) mem_model[w+k] = d[8*k +: 8];
            default: ;
        endcase
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im);
        exp_t e;
        logic [2:0] f3;
        logic take;
        f3 = ins[14:12];
        e = '0;
        e.npc = p + 4;
        case (ins[6:0])
            7'b0110011: begin
                e.sel = op_code(f3, ins[30]); e.alu = alu_ref(e.sel, a, b);
                e.wb = e.alu; e.wenb = 1'b1;
            end
            7'b0010011: begin
                e.sel = op_code(f3, ins[30] && f3 == 3'd5); e.alu = alu_ref(e.sel, a, im);
                e.wb = e.alu; e.wenb = 1'b1;
            end
            7'b0000011: begin
                e.alu = a + im; e.wb = load_ref(f3, e.alu); e.wenb = 1'b1;
            end
            7'b1100011: begin
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) < $signed(b));
                    3'd5: take = !($signed(a) < $signed(b));
                    3'd6: take = (a < b);
                    3'd7: take = !(a < b);
                    default: take = 1'b0;
                endcase
                e.alu = p + im; e.wb = e.alu; e.bt = take;
                if (take) e.npc = p + im;
            end
            7'b0110111: begin e.sel = 4'd10; e.alu = im; e.wb = im; e.wenb = 1'b1; end
            7'b0010111: begin e.alu = p + im; e.wb = e.alu; e.wenb = 1'b1; end
            7'b1101111: begin
                e.alu = p + im; e.wb = p + 4; e.wenb = 1'b1; e.bt = 1'b1; e.npc = p + im;
            end
            7'b1100111: begin
                e.alu = a + im; e.wb = p + 4; e.wenb = 1'b1; e.bt = 1'b1;
                e.npc = (a + im) & 32'hFFFF_FFFE;
            end
            default: begin e.alu = a + im; e.wb = e.alu; end  // stores and unknown opcodes
        endcase
        return e;
    endfunction

    // ---------------- driver ----------------
    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7b);
        logic [31:0] r;
        r = $urandom;
        return {r[31], f7b, r[29:15], f3, r[11:7], op};
    endfunction

    // Called just after a posedge; the store (if any) commits at the next posedge.
    task automatic drive(input string nm, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        instruction = ins; pc = p; rs1_data = a; rs2_data = b; imm = im;
        exp_q.push_back(model(ins, p, a, b, im));
        name_q.push_back(nm);
        if (ins[6:0] == 7'b0100011 && rst) store_ref(ins[14:12], a + im, b);
    endtask

    task automatic step(input string nm, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        @(posedge clk); #1;
        drive(nm, ins, p, a, b, im);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, ".sel_bit"},      {28'd0, sel_bit},      {28'd0, e.sel});
            check({nm, ".alu_out"},      alu_out,               e.alu);
            check({nm, ".wb_data"},      wb_data,               e.wb);
            check({nm, ".wenb"},         {31'd0, wenb},         {31'd0, e.wenb});
            check({nm, ".next_pc"},      next_pc,               e.npc);
            check({nm, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, e.bt});
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, AUI = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // reset state of memory
        for (int i = 0; i < 4; i++)
            step("rst_lw", enc(LD, 3'd2, 0), 32'h100, 32'd0, 32'd0, 32'(i * 260));

        step("add",  enc(R, 3'd0, 0), 0, 5, 7, 0);
        step("sub",  enc(R, 3'd0, 1), 0, 5, 7, 0);
        step("sra",  enc(R, 3'd5, 1), 0, 32'h8000_0000, 4, 0);
        step("sltu", enc(R, 3'd3, 0), 0, 1, 32'hFFFF_FFFF, 0);
        step("addi", enc(I, 3'd0, 1), 0, 10, 0, 32'hFFFF_FFFD);
        step("srai", enc(I, 3'd5, 1), 0, 32'h8000_0000, 0, 32'h0000_0401);
        step("srli", enc(I, 3'd5, 0), 0, 32'h8000_0000, 0, 32'd1);
        step("lui",  enc(LUI, 3'd0, 0), 0, 32'h5555, 0, 32'h1234_5000);
        step("auipc", enc(AUI, 3'd3, 0), 32'h200, 0, 0, 32'h0000_3000);
        step("sw8",  enc(ST, 3'd2, 0), 0, 0, 32'hA1B2_C3D4, 8);
        step("lb8",  enc(LD, 3'd0, 0), 0, 0, 0, 8);
        step("lbu11", enc(LD, 3'd4, 0), 0, 0, 0, 11);
        step("lh10", enc(LD, 3'd1, 0), 0, 0, 0, 10);
        step("lw8",  enc(LD, 3'd2, 0), 0, 0, 0, 8);
        step("sb9",  enc(ST, 3'd0, 0), 0, 4, 32'hFFFF_FF55, 5);
        step("lw8b", enc(LD, 3'd2, 0), 0, 0, 0, 8);
        step("lw_wrap", enc(LD, 3'd2, 0), 0, 32'h0000_4000, 0, 11);
        step("beq",  enc(BR, 3'd0, 0), 32'h40, 3, 3, 32'h10);
        step("blt",  enc(BR, 3'd4, 0), 32'h40, 32'hFFFF_FFFF, 1, 32'h10);
        step("bltu", enc(BR, 3'd6, 0), 32'h40, 32'hFFFF_FFFF, 1, 32'h10);
        step("b010", enc(BR, 3'd2, 0), 32'h40, 3, 3, 32'h10);
        step("jal",  enc(JAL, 3'd0, 0), 32'h20, 0, 0, 32'h100);
        step("jalr", enc(JALR, 3'd0, 0), 32'h20, 32'h1001, 0, 2);
        step("ill",  {25'h0ABCDEF, 7'h7F}, 32'h300, 32'h8, 32'hDEAD_BEEF, 0);
        step("lw8c", enc(LD, 3'd2, 0), 0, 0, 0, 8);

        // asynchronous reset mid-cycle, store held off while rst is low
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'd0;
        drive("rstpulse_lw", enc(LD, 3'd2, 0), 0, 0, 0, 8);
        step("rstlow_sw", enc(ST, 3'd2, 0), 0, 0, 32'h1234_5678, 12);
        @(posedge clk); #1;
        rst = 1'b1;
        drive("after_rst_lw", enc(LD, 3'd2, 0), 0, 0, 0, 12);

        // randomized mix
        for (int n = 0; n < 600; n++) begin
            logic [6:0]  op;
            logic [31:0] a, b, im, p;
            int kind;
            kind = $urandom_range(0, 9);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im = $urandom;
            p  = $urandom & 32'hFFFF_FFFC;
            case (kind)
                0: op = R;
                1: op = I;
                2, 3: op = LD;
                4, 5: op = ST;
                6: op = BR;
                7: op = ($urandom_range(0, 1) != 0) ? LUI : AUI;
                8: op = ($urandom_range(0, 1) != 0) ? JAL : JALR;
                default: begin
                    op = 7'($urandom);
                    while (op inside {R, I, LD, ST, BR, LUI, AUI, JAL, JALR}) op = 7'($urandom);
                end
            endcase
            if (op == LD || op == ST) begin
                a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
                im = 32'($urandom_range(0, 15));
            end
            step("rand", enc(op, 3'($urandom), 1'($urandom)), p, a, b, im);
        end

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
- Combined execute/memory stage of the single-cycle RV32I core: control decode, ALU, and byte-addressable data memory in one block.
- Sits after the decoder, immediate generator and register file; returns writeback data, write enable and next PC to the register file and PC.
- Covers RV32I base integer ops: R-type, I-type ALU, loads, stores, branches, JAL, JALR, LUI, AUIPC. No FENCE/ECALL/CSR.

Parameters:
- MEM_WORDS, 256, data memory depth in 32-bit words; byte address range 0..4*MEM_WORDS-1.
- ADDR_W, 10, byte-address bits used (log2(4*MEM_WORDS)); upper address bits ignored (wrap).

Ports:
- clk  in  1  clock; memory writes occur on the rising edge.
- rst  in  1  asynchronous active-low reset.
- instruction  in  32  current instruction.
- pc  in  32  address of the current instruction.
- rs1_data  in  32  register file read port 1.
- rs2_data  in  32  register file read port 2.
- imm  in  32  sign-extended immediate from the immediate generator.
- sel_bit  out  4  ALU operation code.
- alu_out  out  32  ALU result, also the memory byte address.
- wb_data  out  32  register writeback data.
- wenb  out  1  register write enable.
- next_pc  out  32  next PC value.
- branch_taken  out  1  high when a branch is taken, or for JAL/JALR.

Behaviour:
- Whole datapath is combinational except data-memory writes; single-cycle, 0 latency.
- ALU sel_bit codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - Codes 11-15 give 0.
  - Shift amount = operand B[4:0]. SLT/SLTU produce 32'd1 or 32'd0. Add/sub wrap modulo 2^32.
- Operand A:
  - pc for AUIPC, JAL and branch-target computation.
  - rs1_data otherwise.
- Operand B: rs2_data for R-type; imm for all other types.
- Decode by opcode[6:0], funct3, funct7[5]:
  - 0110011 R-type: op from funct3/funct7[5] (funct3 000 with f7[5]=1 is SUB; 101 with f7[5]=1 is SRA); wenb=1.
  - 0010011 I-ALU: same mapping; funct7[5] is honoured only for funct3=101 (SRAI); ADDI never subtracts.
  - 0000011 loads: ADD, wenb=1.
  - 0100011 stores: ADD, wenb=0.
  - 1100011 branches: ALU=ADD on pc+imm for the target; comparison uses rs1_data vs rs2_data in a separate comparator; wenb=0.
  - 0110111 LUI: PASS_B (imm already shifted), wenb=1.
  - 0010111 AUIPC: pc+imm, wenb=1.
  - 1101111 JAL and 1100111 JALR: wenb=1.
  - Any other opcode: sel_bit=0, wenb=0, no memory write, next_pc=pc+4.
- Branch conditions:
  - BEQ 000, BNE 001, BLT 100 (signed), BGE 101 (signed), BLTU 110, BGEU 111.
  - funct3 010/011 never taken.
- next_pc:
  - pc+imm for a taken branch or JAL.
  - (rs1_data+imm) & ~1 for JALR.
  - pc+4 otherwise.
- wb_data:
  - pc+4 for JAL/JALR.
  - Load data for loads.
  - alu_out otherwise.
- Data memory is little-endian and byte addressable.
- Loads (combinational read):
  - LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
  - Halfword accesses ignore address bit 0; word accesses ignore bits 1:0 (forced alignment, no trap).
  - Load funct3 011/110/111 return 0.
- Stores on the rising clk edge when the opcode is a store:
  - SB writes byte rs2_data[7:0].
  - SH writes rs2_data[15:0] at the aligned halfword.
  - SW writes the aligned word.
  - Other bytes are unchanged. Store funct3 other than 000/001/010 performs no write.
- Read-during-write at the same address: the load sees old contents until the edge; combinational reads show new data after the edge.
- Reset:
  - rst low asynchronously clears all memory to 0.
  - While rst is low, no writes occur.
  - Combinational outputs are unaffected by rst.
- Address wrap: alu_out[ADDR_W-1:0] is used; higher bits are ignored.

Test Plan:
- R-type: ADD rs1=5,rs2=7 -> alu_out=12, wenb=1. SUB 5-7 -> 0xFFFFFFFE. SRA 0x80000000>>4 -> 0xF8000000. SLTU 1<0xFFFFFFFF -> 1.
- I-type: ADDI rs1=10 imm=-3 -> 7. SRAI vs SRLI on 0x80000000 shamt 1 -> 0xC0000000 / 0x40000000. LUI imm=0x12345000 -> wb_data=0x12345000.
- Memory:
  - SW 0xA1B2C3D4 at addr 8, then LB 8 -> 0xFFFFFFD4, LBU 11 -> 0xA1, LH 10 -> 0xFFFFA1B2, LW 8 -> 0xA1B2C3D4.
  - SB 0x55 at addr 9, then LW 8 -> 0xA1B255D4.
- Branches: pc=0x40 imm=0x10, BEQ equal -> next_pc=0x50, branch_taken=1. BLT -1 vs 1 -> taken. BLTU 0xFFFFFFFF vs 1 -> not taken, next_pc=0x44.
- Jumps: JAL pc=0x20 imm=0x100 -> next_pc=0x120, wb_data=0x24. JALR rs1=0x1001 imm=2 -> next_pc=0x1002.
- Reset/illegal: write memory, pulse rst low mid-cycle -> all loads return 0 immediately. Opcode 0x7F -> wenb=0, no memory change, next_pc=pc+4.
